oric_ram_port_mux: RTL and testbench
====================================

ORIC_RAM_PORT_MUX -- requirements
Module: oric_ram_port_mux

Interface
REQ-001 Parameter AW, default 16, memory address width; depth 2^AW words.
REQ-002 Parameter DW, default 8, memory data width.
REQ-003 Parameter NCH, default 2, number of loader write channels (1..4).
REQ-004 Parameter FILL, default all-ones (DW bits), value written by the clear engine.
REQ-005 clk_48  in  1  system clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 cpu_a  in  AW  CPU address.
REQ-008 cpu_d  in  DW  CPU write data.
REQ-009 cpu_cs  in  1  CPU access request, one access per cycle while high.
REQ-010 cpu_we  in  1  CPU write qualifier (valid with cpu_cs).
REQ-011 cpu_q  out  DW  CPU read data.
REQ-012 cpu_wait  out  1  high while CPU accesses are not being served (clear in progress).
REQ-013 ld_valid  in  NCH  per-channel write request.
REQ-014 ld_addr  in  NCH*AW  per-channel address, channel i at bits [i*AW +: AW].
REQ-015 ld_data  in  NCH*DW  per-channel data, same packing.
REQ-016 ld_ready  out  NCH  per-channel accept strobe; a write is consumed on a cycle with ld_valid[i] and ld_ready[i] both high.
REQ-017 clear_start  in  1  one-cycle pulse requesting a new memory clear.
REQ-018 clear_busy  out  1  high while the clear engine owns memory.
REQ-019 mem_a/mem_d/mem_ce/mem_we  out  AW/DW/1/1  registered single-port memory request.
REQ-020 mem_q  in  DW  memory read data, valid one cycle after mem_ce with mem_we low.

Function
REQ-021 The block SHALL have states CLEAR and RUN; reset exits to CLEAR; CLEAR moves to RUN the cycle after address 2^AW-1 is issued; clear_start in RUN moves to CLEAR with counter zeroed.
REQ-022 In CLEAR the block SHALL issue one write of FILL per cycle at counter addresses 0,1,...,2^AW-1, ascending, with cpu_wait and clear_busy high and all ld_ready low.
REQ-023 clear_start asserted while already in CLEAR SHALL restart the counter at 0.
REQ-024 In RUN, when cpu_cs is high, the CPU SHALL own the memory cycle and all ld_ready SHALL be low.
REQ-025 In RUN, when cpu_cs is low and any ld_valid is high, exactly one channel SHALL be granted, round-robin starting after the last granted channel (channel 0 first after reset).
REQ-026 ld_ready[i] SHALL be combinational from current state, cpu_cs and ld_valid, and the granted write SHALL appear on mem_* on the next cycle.
REQ-027 Starvation guard: after 15 consecutive RUN cycles with cpu_cs high and some ld_valid high, the next cycle SHALL serve the loader and raise cpu_wait for that one cycle.
REQ-028 mem_* SHALL be registered: request on cycle N appears on mem_* in N+1; cpu_q SHALL update in N+2 for CPU reads and SHALL hold its last value otherwise.
REQ-029 Idle RUN cycles SHALL drive mem_ce=0, mem_we=0.
REQ-030 Address counter SHALL be AW bits wide; no wrap beyond 2^AW-1 is issued.

Reset
REQ-031 On reset: mem_ce=0, mem_we=0, mem_a=0, mem_d=0, cpu_q=0, ld_ready=0, round-robin pointer=0, starvation counter=0, clear counter=0, state=CLEAR (or RUN per REQ-033), cpu_wait and clear_busy reflecting that state from the first cycle after reset.
REQ-032 Reset asserted mid-clear or mid-transfer SHALL abort it; a consumed loader write already registered on mem_* MAY complete.

Configuration
REQ-033 Macro ORIC_RAM_CLEAR_EN: defined -> clear engine present per REQ-021..023; undefined -> state fixed at RUN, clear_start ignored, clear_busy tied 0, cpu_wait driven only by REQ-027.

Verification
REQ-034 AW=4, FILL=8'hFF, ORIC_RAM_CLEAR_EN: release reset -> 16 consecutive writes of FF to 0..15, clear_busy high 16 cycles, then low.
REQ-035 RUN, CPU write 8'h5A to 3, read 3 on next cycle -> cpu_q=8'h5A two cycles after read request.
REQ-036 NCH=2, both ld_valid held high, cpu_cs low -> grants alternate ch0,ch1,ch0,... one per cycle.
REQ-037 cpu_cs held high, ld_valid[0] high -> ld_ready[0] pulses once every 16th cycle with cpu_wait high that cycle.
REQ-038 clear_start at clear address 7 (in CLEAR) -> next write goes to address 0; reset mid-clear -> clear restarts at 0.
REQ-039 Macro undefined -> first cycle after reset is RUN; CPU read served immediately, clear_busy stays 0.

Source files
------------

// File: rtl/oric_ram_port_mux.sv
// Single-port RAM arbiter: CPU port, NCH round-robin loader channels and a fill/clear engine.
// Define ORIC_RAM_CLEAR_EN to build the clear engine; otherwise the block starts and stays in RUN.
module oric_ram_port_mux #(
  parameter int            AW   = 16,
  parameter int            DW   = 8,
  parameter int            NCH  = 2,
  parameter logic [DW-1:0] FILL = '1
) (
  input  logic              clk_48,
  input  logic              reset,
  input  logic [AW-1:0]     cpu_a,
  input  logic [DW-1:0]     cpu_d,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  output logic [DW-1:0]     cpu_q,
  output logic              cpu_wait,
  input  logic [NCH-1:0]    ld_valid,
  input  logic [NCH*AW-1:0] ld_addr,
  input  logic [NCH*DW-1:0] ld_data,
  output logic [NCH-1:0]    ld_ready,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic [AW-1:0]     mem_a,
  output logic [DW-1:0]     mem_d,
  output logic              mem_ce,
  output logic              mem_we,
  input  logic [DW-1:0]     mem_q
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
`ifdef ORIC_RAM_CLEAR_EN
  localparam state_t ST_RST = ST_CLEAR;
`else
  localparam state_t ST_RST = ST_RUN;
`endif

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_rr, w_rr_nxt;
  logic [3:0]    r_starve, w_starve_nxt;
  logic          r_mem_ce, r_mem_we, w_ce, w_we;
  logic [AW-1:0] r_mem_a, w_a;
  logic [DW-1:0] r_mem_d, w_d;
  logic          r_rd_p1, r_rd_p2;
  logic [DW-1:0] r_cpu_q;

  logic          w_run, w_any_valid, w_force, w_cpu_serve, w_ld_serve, w_cpu_rd;
  logic          w_gfound;
  logic [PW-1:0] w_gidx, w_pidx;
  int            w_idx;

`ifdef ORIC_RAM_CLEAR_EN
  logic [AW-1:0] r_clr_cnt, w_clr_cnt_nxt;
`else
  logic w_unused_clear;
  assign w_unused_clear = clear_start;
`endif

  // Reset gates the combinational grant so ld_ready is low while reset is held.
  assign w_run       = (r_state == ST_RUN) && !reset;
  assign w_any_valid = |ld_valid;
  assign w_force     = w_run && cpu_cs && w_any_valid && (r_starve == 4'd15);
  assign w_cpu_serve = w_run && cpu_cs && !w_force;
  assign w_ld_serve  = w_run && w_gfound && (!cpu_cs || w_force);
  assign w_cpu_rd    = w_cpu_serve && !cpu_we;

  // Round-robin search starting at r_rr, the channel after the last grant.
  always_comb begin
    w_gfound = 1'b0;
    w_gidx   = '0;
    w_idx    = 0;
    w_pidx   = '0;
    for (int k = 0; k < NCH; k++) begin
      w_idx = int'(r_rr) + k;
      if (w_idx >= NCH) w_idx = w_idx - NCH;
      w_pidx = PW'(w_idx);
      if (!w_gfound && ld_valid[w_pidx]) begin
        w_gfound = 1'b1;
        w_gidx   = w_pidx;
      end
    end
  end

  always_comb begin
    ld_ready = '0;
    if (w_ld_serve) ld_ready[w_gidx] = 1'b1;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ce         = 1'b0;
    w_we         = 1'b0;
    w_a          = r_mem_a;
    w_d          = r_mem_d;
    w_rr_nxt     = r_rr;
    w_starve_nxt = 4'd0;
`ifdef ORIC_RAM_CLEAR_EN
    w_clr_cnt_nxt = r_clr_cnt;
`endif
    case (r_state)
      ST_CLEAR: begin
`ifdef ORIC_RAM_CLEAR_EN
        w_ce = 1'b1;
        w_we = 1'b1;
        w_a  = r_clr_cnt;
        w_d  = FILL;
        if (clear_start) begin
          w_clr_cnt_nxt = '0;
        end else if (&r_clr_cnt) begin
          w_clr_cnt_nxt = '0;
          w_state_nxt   = ST_RUN;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        end
`else
        w_state_nxt = ST_RUN;
`endif
      end
      default: begin
        if (w_cpu_serve) begin
          w_ce = 1'b1;
          w_we = cpu_we;
          w_a  = cpu_a;
          w_d  = cpu_d;
        end else if (w_ld_serve) begin
          w_ce     = 1'b1;
          w_we     = 1'b1;
          w_a      = ld_addr[w_gidx*AW +: AW];
          w_d      = ld_data[w_gidx*DW +: DW];
          w_rr_nxt = (int'(w_gidx) == NCH-1) ? '0 : w_gidx + 1'b1;
        end
        if (cpu_cs && w_any_valid && !w_force) w_starve_nxt = r_starve + 1'b1;
`ifdef ORIC_RAM_CLEAR_EN
        if (clear_start) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_cnt_nxt = '0;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk_48) begin
    if (reset) begin
      r_state  <= ST_RST;
      r_rr     <= '0;
      r_starve <= 4'd0;
      r_mem_ce <= 1'b0;
      r_mem_we <= 1'b0;
      r_mem_a  <= '0;
      r_mem_d  <= '0;
      r_rd_p1  <= 1'b0;
      r_rd_p2  <= 1'b0;
      r_cpu_q  <= '0;
`ifdef ORIC_RAM_CLEAR_EN
      r_clr_cnt <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_rr     <= w_rr_nxt;
      r_starve <= w_starve_nxt;
      r_mem_ce <= w_ce;
      r_mem_we <= w_we;
      r_mem_a  <= w_a;
      r_mem_d  <= w_d;
      r_rd_p1  <= w_cpu_rd;
      r_rd_p2  <= r_rd_p1;
      r_cpu_q  <= cpu_q;
`ifdef ORIC_RAM_CLEAR_EN
      r_clr_cnt <= w_clr_cnt_nxt;
`endif
    end
  end

  // Read data passes straight through in its return cycle, then is held.
  assign cpu_q  = r_rd_p2 ? mem_q : r_cpu_q;
  assign mem_ce = r_mem_ce;
  assign mem_we = r_mem_we;
  assign mem_a  = r_mem_a;
  assign mem_d  = r_mem_d;

`ifdef ORIC_RAM_CLEAR_EN
  assign clear_busy = (r_state == ST_CLEAR);
  assign cpu_wait   = (r_state == ST_CLEAR) || w_force;
`else
  assign clear_busy = 1'b0;
  assign cpu_wait   = w_force;
`endif

endmodule

// File: tb/tb_oric_ram_port_mux.sv
// Directed bench for oric_ram_port_mux (AW=4, DW=8, NCH=2) with a synchronous RAM model.
// Clear-engine scenarios run only when ORIC_RAM_CLEAR_EN is defined.
module tb_oric_ram_port_mux;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NCH = 2;

  logic              clk_48 = 1'b0;
  logic              reset;
  logic [AW-1:0]     cpu_a;
  logic [DW-1:0]     cpu_d;
  logic              cpu_cs, cpu_we;
  logic [DW-1:0]     cpu_q;
  logic              cpu_wait;
  logic [NCH-1:0]    ld_valid;
  logic [NCH*AW-1:0] ld_addr;
  logic [NCH*DW-1:0] ld_data;
  logic [NCH-1:0]    ld_ready;
  logic              clear_start, clear_busy;
  logic [AW-1:0]     mem_a;
  logic [DW-1:0]     mem_d;
  logic              mem_ce, mem_we;
  logic [DW-1:0]     mem_q = 8'h00;

  logic [DW-1:0] mem [0:15] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
                                8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F};

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q;

  always #5 clk_48 = ~clk_48;

  always @(posedge clk_48) begin
    if (mem_ce) begin
      if (mem_we) mem[mem_a] <= mem_d;
      else        mem_q <= mem[mem_a];
    end
  end

  oric_ram_port_mux #(.AW(AW), .DW(DW), .NCH(NCH), .FILL(8'hFF)) dut (
    .clk_48(clk_48), .reset(reset),
    .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_cs(cpu_cs), .cpu_we(cpu_we),
    .cpu_q(cpu_q), .cpu_wait(cpu_wait),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .mem_a(mem_a), .mem_d(mem_d), .mem_ce(mem_ce), .mem_we(mem_we), .mem_q(mem_q)
  );

  task automatic tick;
    @(posedge clk_48);
    #1;
  endtask

  task automatic test_reset;
    logic exp_busy;
`ifdef ORIC_RAM_CLEAR_EN
    exp_busy = 1'b1;
`else
    exp_busy = 1'b0;
`endif
    reset = 1'b1; cpu_cs = 1'b0; cpu_we = 1'b0; cpu_a = '0; cpu_d = '0;
    ld_valid = '0; ld_addr = '0; ld_data = '0; clear_start = 1'b0;
    tick; tick;
    checks++; if ({mem_ce, mem_we} !== 2'b00) begin errors++; $display("FAIL reset_ce_we: got %b expected 00", {mem_ce, mem_we}); end
    checks++; if ({mem_a, mem_d} !== 12'h000) begin errors++; $display("FAIL reset_a_d: got %h expected 000", {mem_a, mem_d}); end
    checks++; if (cpu_q !== 8'h00) begin errors++; $display("FAIL reset_cpu_q: got %h expected 00", cpu_q); end
    ld_valid = 2'b11; #1;
    checks++; if (ld_ready !== 2'b00) begin errors++; $display("FAIL reset_ld_ready: got %b expected 00", ld_ready); end
    ld_valid = 2'b00;
    checks++; if (clear_busy !== exp_busy) begin errors++; $display("FAIL reset_clear_busy: got %b expected %b", clear_busy, exp_busy); end
    checks++; if (cpu_wait !== exp_busy) begin errors++; $display("FAIL reset_cpu_wait: got %b expected %b", cpu_wait, exp_busy); end
    exp_q = 8'h00;
  endtask

  task automatic test_run_after_reset;
    reset = 1'b0; cpu_cs = 1'b1; cpu_we = 1'b0; cpu_a = 4'd5; #1;
    checks++; if ({clear_busy, cpu_wait} !== 2'b00) begin errors++; $display("FAIL run_busy_wait: got %b expected 00", {clear_busy, cpu_wait}); end
    tick;
    checks++; if ({mem_ce, mem_we, mem_a} !== {2'b10, 4'd5}) begin errors++; $display("FAIL run_first_read: got %b expected 100101", {mem_ce, mem_we, mem_a}); end
    cpu_cs = 1'b0;
    tick;
    checks++; if (cpu_q !== 8'h15) begin errors++; $display("FAIL run_read_q: got %h expected 15", cpu_q); end
    tick;
    checks++; if (cpu_q !== 8'h15) begin errors++; $display("FAIL run_read_hold: got %h expected 15", cpu_q); end
    exp_q = 8'h15;
  endtask

`ifdef ORIC_RAM_CLEAR_EN
  task automatic test_clear;
    int n;
    reset = 1'b0; ld_valid = 2'b11;
    for (int k = 0; k < 16; k++) begin
      #1;
      checks++; if ({clear_busy, cpu_wait, ld_ready} !== 4'b1100) begin errors++; $display("FAIL clear_flags k=%0d: got %b expected 1100", k, {clear_busy, cpu_wait, ld_ready}); end
      if (k > 0) begin
        checks++; if ({mem_ce, mem_we, mem_a, mem_d} !== {2'b11, 4'(k-1), 8'hFF}) begin errors++; $display("FAIL clear_write k=%0d: got a=%0d d=%h ce=%b we=%b expected a=%0d d=ff", k, mem_a, mem_d, mem_ce, mem_we, k-1); end
      end
      tick;
    end
    ld_valid = 2'b00;
    checks++; if ({clear_busy, mem_a} !== {1'b0, 4'd15}) begin errors++; $display("FAIL clear_end: got busy=%b a=%0d expected busy=0 a=15", clear_busy, mem_a); end
    clear_start = 1'b1; tick; clear_start = 1'b0;
    checks++; if (clear_busy !== 1'b1) begin errors++; $display("FAIL clear_restart_busy: got %b expected 1", clear_busy); end
    repeat (7) tick;
    clear_start = 1'b1; tick; clear_start = 1'b0;
    checks++; if (mem_a !== 4'd7) begin errors++; $display("FAIL clear_at7: got %0d expected 7", mem_a); end
    tick;
    checks++; if (mem_a !== 4'd0) begin errors++; $display("FAIL clear_restart_addr: got %0d expected 0", mem_a); end
    tick; tick;
    reset = 1'b1; tick;
    checks++; if (mem_ce !== 1'b0) begin errors++; $display("FAIL clear_reset_ce: got %b expected 0", mem_ce); end
    reset = 1'b0; tick;
    checks++; if ({mem_ce, mem_a, clear_busy} !== {1'b1, 4'd0, 1'b1}) begin errors++; $display("FAIL clear_after_reset: got ce=%b a=%0d busy=%b expected ce=1 a=0 busy=1", mem_ce, mem_a, clear_busy); end
    n = 0;
    while (clear_busy && n < 40) begin tick; n++; end
    checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL clear_timeout: busy=%b after %0d cycles expected 0", clear_busy, n); end
    checks++; if (mem[3] !== 8'hFF) begin errors++; $display("FAIL clear_mem_fill: got %h expected ff", mem[3]); end
    exp_q = 8'h00;
  endtask
`endif

  task automatic test_cpu_wr_rd;
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_a = 4'd3; cpu_d = 8'h5A;
    tick;
    checks++; if ({mem_ce, mem_we, mem_a, mem_d} !== {2'b11, 4'd3, 8'h5A}) begin errors++; $display("FAIL cpu_write: got ce=%b we=%b a=%0d d=%h expected 1 1 3 5a", mem_ce, mem_we, mem_a, mem_d); end
    cpu_we = 1'b0;
    tick;
    checks++; if ({mem_ce, mem_we, mem_a} !== {2'b10, 4'd3}) begin errors++; $display("FAIL cpu_read_req: got ce=%b we=%b a=%0d expected 1 0 3", mem_ce, mem_we, mem_a); end
    checks++; if (cpu_q !== exp_q) begin errors++; $display("FAIL cpu_q_hold: got %h expected %h", cpu_q, exp_q); end
    cpu_cs = 1'b0;
    tick;
    checks++; if (cpu_q !== 8'h5A) begin errors++; $display("FAIL cpu_read_q: got %h expected 5a", cpu_q); end
    exp_q = 8'h5A;
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_rdy;
    cpu_cs = 1'b0;
    ld_addr = {4'd9, 4'd8};
    ld_data = {8'hB1, 8'hA0};
    ld_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (ld_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant k=%0d: got %b expected %b", k, ld_ready, exp_rdy); end
      if (k > 0) begin
        checks++; if (mem_a !== ((k % 2 == 1) ? 4'd8 : 4'd9)) begin errors++; $display("FAIL rr_write k=%0d: got a=%0d", k, mem_a); end
      end
      tick;
    end
    checks++; if ({mem_we, mem_a, mem_d} !== {1'b1, 4'd9, 8'hB1}) begin errors++; $display("FAIL rr_last: got we=%b a=%0d d=%h expected 1 9 b1", mem_we, mem_a, mem_d); end
    ld_valid = 2'b10; #1;
    checks++; if (ld_ready !== 2'b10) begin errors++; $display("FAIL rr_only_ch1: got %b expected 10", ld_ready); end
    tick;
    ld_valid = 2'b01; #1;
    checks++; if (ld_ready !== 2'b01) begin errors++; $display("FAIL rr_only_ch0: got %b expected 01", ld_ready); end
    tick;
    ld_valid = 2'b11; #1;
    checks++; if (ld_ready !== 2'b10) begin errors++; $display("FAIL rr_after_ch0: got %b expected 10", ld_ready); end
    tick;
  endtask

  task automatic test_starvation;
    logic forced;
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_a = 4'd0; ld_valid = 2'b11; #1;
    checks++; if (ld_ready !== 2'b00) begin errors++; $display("FAIL cpu_owns: got %b expected 00", ld_ready); end
    ld_valid = 2'b01;
    for (int k = 0; k < 32; k++) begin
      #1;
      forced = (k % 16 == 15);
      checks++; if ({ld_ready, cpu_wait} !== {1'b0, forced, forced}) begin errors++; $display("FAIL starve k=%0d: got rdy=%b wait=%b expected rdy=0%b wait=%b", k, ld_ready, cpu_wait, forced, forced); end
      if (k > 0) begin
        checks++; if (mem_we !== (k % 16 == 0)) begin errors++; $display("FAIL starve_mem_we k=%0d: got %b", k, mem_we); end
      end
      if (k == 16) begin
        checks++; if ({mem_a, mem_d} !== {4'd8, 8'hA0}) begin errors++; $display("FAIL starve_write: got a=%0d d=%h expected 8 a0", mem_a, mem_d); end
      end
      tick;
    end
    cpu_cs = 1'b0; ld_valid = 2'b00;
    tick; tick;
    checks++; if ({mem_ce, mem_we, cpu_wait} !== 3'b000) begin errors++; $display("FAIL idle: got ce=%b we=%b wait=%b expected 000", mem_ce, mem_we, cpu_wait); end
  endtask

  initial begin
    test_reset;
`ifdef ORIC_RAM_CLEAR_EN
    test_clear;
`else
    test_run_after_reset;
`endif
    test_cpu_wr_rd;
    test_round_robin;
    test_starvation;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
